// File: rtl/fan_output_collector_if.sv
// fan_output_collector_if
//  Bundles the sparse psum input side (from fan_network plus downstream ready)
//  and the serialized psum output stream of fan_output_collector.
//  Modports:
//   master : drives i_valid / i_data_bus / i_ready, observes the output stream
//   slave  : the collector itself
//  Optional: FAN_COLLECT_TAG_EN adds o_tag (8-bit vector sequence number).
interface fan_output_collector_if #(
    parameter int unsigned DATA_TYPE  = 32,
    parameter int unsigned NUM_PES    = 4,
    parameter int unsigned LOG2_PES   = 2,
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_PES-1:0]           i_valid;
    logic [NUM_PES*DATA_TYPE-1:0] i_data_bus;
    logic                         i_ready;
    logic                         o_valid;
    logic [DATA_TYPE-1:0]         o_data;
    logic [LOG2_PES-1:0]          o_lane;
    logic                         o_last;
    logic [LEVEL_W-1:0]           o_fifo_level;
    logic                         o_overflow;

`ifdef FAN_COLLECT_TAG_EN
    logic [7:0]                   o_tag;

    modport master (
        output i_valid, i_data_bus, i_ready,
        input  o_valid, o_data, o_lane, o_last, o_fifo_level, o_overflow, o_tag
    );

    modport slave (
        input  i_valid, i_data_bus, i_ready,
        output o_valid, o_data, o_lane, o_last, o_fifo_level, o_overflow, o_tag
    );
`else
    modport master (
        output i_valid, i_data_bus, i_ready,
        input  o_valid, o_data, o_lane, o_last, o_fifo_level, o_overflow
    );

    modport slave (
        input  i_valid, i_data_bus, i_ready,
        output o_valid, o_data, o_lane, o_last, o_fifo_level, o_overflow
    );
`endif

endinterface

// File: rtl/fan_output_collector.sv
// fan_output_collector
//  Consumes the sparse per-PE psum vectors of fan_network, buffers each
//  non-empty vector in a FIFO and serializes the valid lanes, lowest PE index
//  first, onto one valid/ready stream. fan_network cannot stall, so vectors
//  arriving while the FIFO is full (and no pop happens) are dropped and the
//  sticky overflow flag is raised.
//  Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   bus.i_valid              per-lane psum valid
//   bus.i_data_bus           psums, lane k at [k*DATA_TYPE +: DATA_TYPE]
//   bus.i_ready              downstream ready
//   bus.o_valid/o_data       output psum stream
//   bus.o_lane               PE index of the current psum
//   bus.o_last               last psum of the current vector
//   bus.o_fifo_level         FIFO occupancy (serializer entry excluded)
//   bus.o_overflow           sticky drop flag
//  Optional feature macro: FAN_COLLECT_TAG_EN adds bus.o_tag, an 8-bit
//  sequence number of the vector the current psum belongs to.
module fan_output_collector #(
    parameter int unsigned DATA_TYPE  = 32,
    parameter int unsigned NUM_PES    = 4,
    parameter int unsigned LOG2_PES   = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fan_output_collector_if.slave bus
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LEVEL_W = PTR_W + 1;
    localparam int unsigned BUS_W   = NUM_PES * DATA_TYPE;
`ifdef FAN_COLLECT_TAG_EN
    localparam int unsigned TAG_W   = 8;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and bookkeeping
    logic [NUM_PES-1:0] fifo_mask [FIFO_DEPTH];
    logic [BUS_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] level_d;

    // Serializer
    logic [NUM_PES-1:0] r_mask;
    logic [NUM_PES-1:0] mask_d;
    logic [BUS_W-1:0]   r_data;
    logic [BUS_W-1:0]   data_d;
    logic [LOG2_PES-1:0] lane_d;
    logic [DATA_TYPE-1:0] odata_d;

    logic hs;
    logic pop;
    logic push;
    logic drop;
    logic any_in;

`ifdef FAN_COLLECT_TAG_EN
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] fifo_tag [FIFO_DEPTH];
`endif

    // Index of the lowest set bit (0 when the mask is empty)
    function automatic logic [LOG2_PES-1:0] low_idx(input logic [NUM_PES-1:0] m);
        logic found;
        low_idx = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_PES; k++) begin
            if (m[k] && !found) begin
                low_idx = LOG2_PES'(k);
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic is_one_hot(input logic [NUM_PES-1:0] m);
        is_one_hot = (m != '0) && ((m & (m - NUM_PES'(1))) == '0);
    endfunction

    // Push/pop decisions; a pop frees a slot for a same-cycle push
    always_comb begin
        any_in = (bus.i_valid != '0);
        hs     = bus.o_valid & bus.i_ready;
        pop    = (level != '0) && ((state_q == ST_IDLE) || (hs && bus.o_last));
        push   = any_in && ((level < LEVEL_W'(FIFO_DEPTH)) || pop);
        drop   = any_in && !push;
    end

    // Occupancy update
    always_comb begin
        level_d = level;
        case ({push, pop})
            2'b10:   level_d = level + LEVEL_W'(1);
            2'b01:   level_d = level - LEVEL_W'(1);
            default: level_d = level;
        endcase
    end

    // Serializer next state: retire the lowest lane on handshake, reload on pop
    always_comb begin
        state_d = state_q;
        mask_d  = r_mask;
        data_d  = r_data;
        if (hs) begin
            mask_d = r_mask & ~(NUM_PES'(1) << low_idx(r_mask));
        end
        if (pop) begin
            mask_d = fifo_mask[rd_ptr];
            data_d = fifo_data[rd_ptr];
        end
        case (state_q)
            ST_IDLE: if (pop) state_d = ST_EMIT;
            ST_EMIT: if (mask_d == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next output beat, derived from the next serializer contents
    always_comb begin
        lane_d  = low_idx(mask_d);
        odata_d = '0;
        for (int unsigned k = 0; k < NUM_PES; k++) begin
            if (lane_d == LOG2_PES'(k)) begin
                odata_d = data_d[k*DATA_TYPE +: DATA_TYPE];
            end
        end
    end

    // FSM and serializer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_mask  <= '0;
            r_data  <= '0;
        end else begin
            state_q <= state_d;
            r_mask  <= mask_d;
            r_data  <= data_d;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            bus.o_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_d;
            if (drop) bus.o_overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mask[wr_ptr] <= bus.i_valid;
            fifo_data[wr_ptr] <= bus.i_data_bus;
        end
    end

    // Registered output stream, mirrors the next serializer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_valid      <= 1'b0;
            bus.o_data       <= '0;
            bus.o_lane       <= '0;
            bus.o_last       <= 1'b0;
            bus.o_fifo_level <= '0;
        end else begin
            bus.o_valid      <= (mask_d != '0);
            bus.o_data       <= odata_d;
            bus.o_lane       <= lane_d;
            bus.o_last       <= is_one_hot(mask_d);
            bus.o_fifo_level <= level_d;
        end
    end

`ifdef FAN_COLLECT_TAG_EN
    // Sequence numbers: only accepted vectors consume a tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt   <= '0;
            bus.o_tag <= '0;
        end else begin
            if (push) tag_cnt   <= tag_cnt + TAG_W'(1);
            if (pop)  bus.o_tag <= fifo_tag[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_tag[wr_ptr] <= tag_cnt;
    end
`endif

endmodule

// File: tb/tb_fan_output_collector.sv
module tb_fan_output_collector;
    localparam int unsigned DW = 32;
    localparam int unsigned NP = 4;
    localparam int unsigned LP = 2;
    localparam int unsigned FD = 8;

    typedef struct {
        logic [LP-1:0] lane;
        logic [DW-1:0] data;
        logic          last;
        logic [7:0]    tag;
    } beat_t;

    typedef struct {
        logic [NP-1:0]    mask;
        logic [NP*DW-1:0] data;
        logic [7:0]       tag;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fan_output_collector_if #(
        .DATA_TYPE(DW), .NUM_PES(NP), .LOG2_PES(LP), .FIFO_DEPTH(FD)
    ) bus ();

    fan_output_collector #(
        .DATA_TYPE(DW), .NUM_PES(NP), .LOG2_PES(LP), .FIFO_DEPTH(FD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference model: waiting vectors and beats still owed for the current one
    vec_t  fq[$];
    beat_t cur[$];
    logic       m_ovf;
    logic [7:0] m_tag;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        fq.delete();
        cur.delete();
        m_ovf = 1'b0;
        m_tag = 8'd0;
    endtask

    // One clock edge of the reference behaviour, given the sampled inputs
    task automatic model_edge(input logic [NP-1:0] iv, input logic [NP*DW-1:0] d, input logic rdy);
        bit    hs;
        bit    pop;
        bit    push;
        vec_t  v;
        vec_t  nv;
        beat_t b;
        hs   = (cur.size() > 0) && rdy;
        pop  = (fq.size() > 0) && ((cur.size() == 0) || (hs && cur.size() == 1));
        push = (iv != '0) && ((fq.size() < FD) || pop);
        if (hs) void'(cur.pop_front());
        if (pop) begin
            v = fq.pop_front();
            for (int k = 0; k < NP; k++) begin
                if (v.mask[k]) begin
                    b.lane = LP'(k);
                    b.data = v.data[k*DW +: DW];
                    b.last = ((v.mask >> (k + 1)) == '0);
                    b.tag  = v.tag;
                    cur.push_back(b);
                end
            end
        end
        if (push) begin
            nv.mask = iv;
            nv.data = d;
            nv.tag  = m_tag;
            fq.push_back(nv);
            m_tag = m_tag + 8'd1;
        end else if (iv != '0) begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("o_valid", 64'(bus.o_valid), 64'(cur.size() > 0));
        chk("o_fifo_level", 64'(bus.o_fifo_level), 64'(fq.size()));
        chk("o_overflow", 64'(bus.o_overflow), 64'(m_ovf));
        if (cur.size() > 0) begin
            chk("o_lane", 64'(bus.o_lane), 64'(cur[0].lane));
            chk("o_data", 64'(bus.o_data), 64'(cur[0].data));
            chk("o_last", 64'(bus.o_last), 64'(cur[0].last));
`ifdef FAN_COLLECT_TAG_EN
            chk("o_tag", 64'(bus.o_tag), 64'(cur[0].tag));
`endif
        end
    endtask

    task automatic step(input logic [NP-1:0] iv, input logic [NP*DW-1:0] d, input logic rdy);
        @(negedge clk);
        bus.i_valid    = iv;
        bus.i_data_bus = d;
        bus.i_ready    = rdy;
        @(posedge clk);
        model_edge(iv, d, rdy);
        #1;
        compare_all();
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic apply_reset();
        #2;
        bus.i_valid    = '0;
        bus.i_data_bus = '0;
        bus.i_ready    = 1'b0;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_o_fifo_level", 64'(bus.o_fifo_level), 64'd0);
        chk("rst_o_overflow", 64'(bus.o_overflow), 64'd0);
        chk("rst_o_last", 64'(bus.o_last), 64'd0);
        chk("rst_o_lane", 64'(bus.o_lane), 64'd0);
        chk("rst_o_data", 64'(bus.o_data), 64'd0);
`ifdef FAN_COLLECT_TAG_EN
        chk("rst_o_tag", 64'(bus.o_tag), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (fq.size() > 0 || cur.size() > 0); i++) begin
            step('0, '0, 1'b1);
        end
        chk("drain_done_valid", 64'(bus.o_valid), 64'd0);
        chk("drain_done_level", 64'(bus.o_fifo_level), 64'd0);
    endtask

    function automatic logic [NP*DW-1:0] rand_bus();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NP-1:0] rand_mask_nz();
        return NP'($urandom_range(1, 15));
    endfunction

    initial begin
        int vcnt;
        int lcnt;
        logic [NP-1:0] iv;
        bus.i_valid    = '0;
        bus.i_data_bus = '0;
        bus.i_ready    = 1'b0;
        model_clear();

        apply_reset();

        // Basic serialization: 1010, lanes {4,3,2,1}
        step(4'b1010, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
        chk("t1_no_valid_yet", 64'(bus.o_valid), 64'd0);
        step('0, '0, 1'b1);
        chk("t1_b0_valid", 64'(bus.o_valid), 64'd1);
        chk("t1_b0_lane", 64'(bus.o_lane), 64'd1);
        chk("t1_b0_data", 64'(bus.o_data), 64'd2);
        chk("t1_b0_last", 64'(bus.o_last), 64'd0);
        step('0, '0, 1'b1);
        chk("t1_b1_lane", 64'(bus.o_lane), 64'd3);
        chk("t1_b1_data", 64'(bus.o_data), 64'd4);
        chk("t1_b1_last", 64'(bus.o_last), 64'd1);
        step('0, '0, 1'b1);
        chk("t1_idle", 64'(bus.o_valid), 64'd0);

        // Back-to-back vectors: 5 consecutive beats, two lasts
        vcnt = 0;
        lcnt = 0;
        step(4'b1111, rand_bus(), 1'b1);
        step(4'b0001, rand_bus(), 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (bus.o_valid) vcnt++;
            if (bus.o_valid && bus.o_last) lcnt++;
            step('0, '0, 1'b1);
        end
        chk("t2_beats", 64'(vcnt), 64'd5);
        chk("t2_lasts", 64'(lcnt), 64'd2);

        // Backpressure after the first beat of 0111
        step(4'b0111, rand_bus(), 1'b1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step('0, '0, 1'b0);
            chk("t3_hold_lane", 64'(bus.o_lane), 64'd1);
        end
        drain();

        // Overflow: 10 vectors with downstream stalled
        for (int i = 0; i < 10; i++) begin
            step(rand_mask_nz(), rand_bus(), 1'b0);
            if (i == 8) chk("t4_no_ovf_at_9", 64'(bus.o_overflow), 64'd0);
        end
        chk("t4_level_full", 64'(bus.o_fifo_level), 64'd8);
        chk("t4_overflow", 64'(bus.o_overflow), 64'd1);
        drain();

        // Full FIFO with a same-cycle pop accepts the new vector
        apply_reset();
        for (int i = 0; i < 9; i++) step(4'b0100, rand_bus(), 1'b0);
        chk("t5_level_before", 64'(bus.o_fifo_level), 64'd8);
        step(4'b0010, rand_bus(), 1'b1);
        chk("t5_level_after", 64'(bus.o_fifo_level), 64'd8);
        chk("t5_no_overflow", 64'(bus.o_overflow), 64'd0);
        drain();

        // Async reset in the middle of a burst
        for (int i = 0; i < 6; i++) step(rand_mask_nz(), rand_bus(), 1'($urandom_range(0, 1)));
        apply_reset();
        step(4'b1000, rand_bus(), 1'b1);
        step('0, '0, 1'b0);
        chk("t6_valid_after_reset", 64'(bus.o_valid), 64'd1);
        chk("t6_lane_after_reset", 64'(bus.o_lane), 64'd3);
`ifdef FAN_COLLECT_TAG_EN
        chk("t6_tag_after_reset", 64'(bus.o_tag), 64'd0);
`endif
        drain();

        // Randomized traffic with occasional stalls long enough to overflow
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            iv = ($urandom_range(0, 3) == 0) ? '0 : rand_mask_nz();
            if ((i % 150) > 120) step(iv, rand_bus(), 1'b0);
            else step(iv, rand_bus(), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
